// File: rtl/mips_defs.sv
// Shared MIPS core definitions: data-memory op encodings and op classifiers.
package mips_defs;

  typedef enum logic [3:0] {
    MemNone = 4'd0,
    MemLw   = 4'd1,
    MemLh   = 4'd2,
    MemLhu  = 4'd3,
    MemLb   = 4'd4,
    MemLbu  = 4'd5,
    MemSw   = 4'd6,
    MemSh   = 4'd7,
    MemSb   = 4'd8
  } mem_op_e;

  function automatic logic is_load(input logic [3:0] op);
    return (op == MemLw) || (op == MemLh) || (op == MemLhu) || (op == MemLb) || (op == MemLbu);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == MemSw) || (op == MemSh) || (op == MemSb);
  endfunction

endpackage

// File: rtl/dm_ext.sv
// Load extractor: selects the addressed half/byte of a memory word and extends it.
module dm_ext
  import mips_defs::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] res
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  // Lane selection and sign/zero extension by load type.
  always_comb begin
    res      = '0;
    half     = addr_lo[1] ? word[31:16] : word[15:0];
    byte_sel = word[8*addr_lo +: 8];
    case (mem_op_e'(op))
      MemLw:   res = word;
      MemLh:   res = {{16{half[15]}}, half};
      MemLhu:  res = {16'h0000, half};
      MemLb:   res = {{24{byte_sel[7]}}, byte_sel};
      MemLbu:  res = {24'h000000, byte_sel};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/dm_ctrl.sv
// M/W-stage data-memory controller: drives the data bus from M, registers the
// returned word into W, extracts load data and tracks sticky access errors.
module dm_ctrl
  import mips_defs::*;
#(
  parameter int unsigned DM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic [3:0]  m_mem_op,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_store_data,
  input  logic        m_grf_we,
  input  logic [4:0]  m_grf_addr,
  input  logic [31:0] m_wb_data,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_inst_addr,
  input  logic [31:0] m_data_rdata,
  output logic        w_grf_we,
  output logic [4:0]  w_grf_addr,
  output logic [31:0] w_grf_wdata,
  output logic [31:0] w_inst_addr,
  output logic        err,
  output logic [31:0] err_pc,
  output logic [7:0]  err_cnt
);

  localparam logic [31:0] DmBytes = 32'(DM_WORDS * 4);

  mem_op_e op_e;
  logic    is_mem;
  logic    misalign;
  logic    out_of_range;
  logic    fault;

  logic        we_q;
  logic [4:0]  grf_addr_q;
  logic [31:0] pc_q;
  logic [3:0]  op_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] wb_data_q;
  logic [31:0] rdata_q;
  logic [31:0] ext_data;

  logic        err_q;
  logic [31:0] err_pc_q;
  logic [7:0]  err_cnt_q;

  assign op_e        = mem_op_e'(m_mem_op);
  assign m_data_addr = m_addr;
  assign m_inst_addr = m_pc;

  // Fault detection: misaligned word/half access or address beyond the memory.
  always_comb begin
    is_mem       = is_load(m_mem_op) || is_store(m_mem_op);
    misalign     = 1'b0;
    out_of_range = m_addr >= DmBytes;
    case (op_e)
      MemLw, MemSw:         misalign = m_addr[1:0] != 2'b00;
      MemLh, MemLhu, MemSh: misalign = m_addr[0];
      default:              misalign = 1'b0;
    endcase
    fault = m_valid && is_mem && (misalign || out_of_range);
  end

  // Store lane replication and byte enables; no write on fault, bubble or reset.
  always_comb begin
    m_data_wdata  = m_store_data;
    m_data_byteen = 4'b0000;
    case (op_e)
      MemSh:   m_data_wdata = {2{m_store_data[15:0]}};
      MemSb:   m_data_wdata = {4{m_store_data[7:0]}};
      default: m_data_wdata = m_store_data;
    endcase
    if (m_valid && !fault && !reset) begin
      case (op_e)
        MemSw:   m_data_byteen = 4'b1111;
        MemSh:   m_data_byteen = m_addr[1] ? 4'b1100 : 4'b0011;
        MemSb:   m_data_byteen = 4'b0001 << m_addr[1:0];
        default: m_data_byteen = 4'b0000;
      endcase
    end
  end

  // M/W pipeline register; loads every cycle, faulting instructions never write the GRF.
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q       <= 1'b0;
      grf_addr_q <= '0;
      pc_q       <= '0;
      op_q       <= '0;
      addr_lo_q  <= '0;
      wb_data_q  <= '0;
      rdata_q    <= '0;
    end else begin
      we_q       <= m_valid && m_grf_we && !fault;
      grf_addr_q <= m_grf_addr;
      pc_q       <= m_pc;
      op_q       <= m_mem_op;
      addr_lo_q  <= m_addr[1:0];
      wb_data_q  <= m_wb_data;
      rdata_q    <= m_data_rdata;
    end
  end

  // Sticky error state: first faulting PC and a saturating fault count.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q     <= 1'b0;
      err_pc_q  <= '0;
      err_cnt_q <= '0;
    end else if (fault) begin
      err_q <= 1'b1;
      if (!err_q) err_pc_q <= m_pc;
      if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  dm_ext u_dm_ext (
    .op      (op_q),
    .addr_lo (addr_lo_q),
    .word    (rdata_q),
    .res     (ext_data)
  );

  assign w_grf_we    = we_q;
  assign w_grf_addr  = grf_addr_q;
  assign w_inst_addr = pc_q;
  assign w_grf_wdata = is_load(op_q) ? ext_data : wb_data_q;
  assign err         = err_q;
  assign err_pc      = err_pc_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_dm_ctrl.sv
// Directed bench for dm_ctrl with a small byte-enabled data memory model.
module tb_dm_ctrl;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [3:0]  m_mem_op;
  logic [31:0] m_addr;
  logic [31:0] m_store_data;
  logic        m_grf_we;
  logic [4:0]  m_grf_addr;
  logic [31:0] m_wb_data;
  logic [31:0] m_data_addr;
  logic [31:0] m_data_wdata;
  logic [3:0]  m_data_byteen;
  logic [31:0] m_inst_addr;
  logic [31:0] m_data_rdata;
  logic        w_grf_we;
  logic [4:0]  w_grf_addr;
  logic [31:0] w_grf_wdata;
  logic [31:0] w_inst_addr;
  logic        err;
  logic [31:0] err_pc;
  logic [7:0]  err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [4096];

  always #5 clk = ~clk;

  dm_ctrl #(.DM_WORDS(4096)) dut (
    .clk           (clk),
    .reset         (reset),
    .m_valid       (m_valid),
    .m_pc          (m_pc),
    .m_mem_op      (m_mem_op),
    .m_addr        (m_addr),
    .m_store_data  (m_store_data),
    .m_grf_we      (m_grf_we),
    .m_grf_addr    (m_grf_addr),
    .m_wb_data     (m_wb_data),
    .m_data_addr   (m_data_addr),
    .m_data_wdata  (m_data_wdata),
    .m_data_byteen (m_data_byteen),
    .m_inst_addr   (m_inst_addr),
    .m_data_rdata  (m_data_rdata),
    .w_grf_we      (w_grf_we),
    .w_grf_addr    (w_grf_addr),
    .w_grf_wdata   (w_grf_wdata),
    .w_inst_addr   (w_inst_addr),
    .err           (err),
    .err_pc        (err_pc),
    .err_cnt       (err_cnt)
  );

  // Memory read is combinational; out-of-range addresses read as zero.
  assign m_data_rdata = (m_data_addr < 32'h4000) ? mem[m_data_addr[13:2]] : 32'h0;

  // Byte-enabled write commits at the rising edge.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (m_data_byteen[b] && m_data_addr < 32'h4000)
        mem[m_data_addr[13:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input logic [31:0] pc, input logic we,
                       input logic [4:0] ga, input logic [31:0] wb);
    @(negedge clk);
    m_valid      = v;
    m_mem_op     = op;
    m_addr       = addr;
    m_store_data = data;
    m_pc         = pc;
    m_grf_we     = we;
    m_grf_addr   = ga;
    m_wb_data    = wb;
    #1;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    reset = 1'b1;
    // Valid store held in M during reset must not write.
    drive(1'b1, MemSw, 32'h20, 32'hFFFF_FFFF, 32'h2FFC, 1'b0, 5'd0, 32'h0);
    check("byteen_in_reset", 32'(m_data_byteen), 32'h0);
    step;
    step;
    check("rst_w_we", 32'(w_grf_we), 32'h0);
    check("rst_w_addr", 32'(w_grf_addr), 32'h0);
    check("rst_w_wdata", w_grf_wdata, 32'h0);
    check("rst_w_pc", w_inst_addr, 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_err_pc", err_pc, 32'h0);
    check("rst_err_cnt", 32'(err_cnt), 32'h0);
    @(negedge clk);
    reset   = 1'b0;
    m_valid = 1'b0;

    // SB 0xAB at 0x6
    drive(1'b1, MemSb, 32'h6, 32'h0000_00AB, 32'h3000, 1'b0, 5'd0, 32'h0);
    check("sb_byteen", 32'(m_data_byteen), 32'h4);
    check("sb_wdata", m_data_wdata, 32'hABAB_ABAB);
    check("sb_addr", m_data_addr, 32'h6);
    check("sb_inst_addr", m_inst_addr, 32'h3000);
    step;
    drive(1'b1, MemLb, 32'h6, 32'h0, 32'h3004, 1'b1, 5'd5, 32'h0);
    check("lb_byteen", 32'(m_data_byteen), 32'h0);
    step;
    check("lb_wdata", w_grf_wdata, 32'hFFFF_FFAB);
    check("lb_we", 32'(w_grf_we), 32'h1);
    check("lb_ga", 32'(w_grf_addr), 32'h5);
    check("lb_pc", w_inst_addr, 32'h3004);
    drive(1'b1, MemLbu, 32'h6, 32'h0, 32'h3008, 1'b1, 5'd6, 32'h0);
    step;
    check("lbu_wdata", w_grf_wdata, 32'h0000_00AB);

    // SH 0x8001 at 0x2 (upper store-data bits must be ignored)
    drive(1'b1, MemSh, 32'h2, 32'hDEAD_8001, 32'h300C, 1'b0, 5'd0, 32'h0);
    check("sh_byteen", 32'(m_data_byteen), 32'hC);
    check("sh_wdata", m_data_wdata, 32'h8001_8001);
    step;
    drive(1'b1, MemLh, 32'h2, 32'h0, 32'h3010, 1'b1, 5'd7, 32'h0);
    step;
    check("lh_wdata", w_grf_wdata, 32'hFFFF_8001);
    drive(1'b1, MemLhu, 32'h2, 32'h0, 32'h3014, 1'b1, 5'd7, 32'h0);
    step;
    check("lhu_wdata", w_grf_wdata, 32'h0000_8001);

    // SW then LW at 0x10
    drive(1'b1, MemSw, 32'h10, 32'h1234_5678, 32'h301C, 1'b0, 5'd0, 32'h0);
    check("sw_byteen", 32'(m_data_byteen), 32'hF);
    check("sw_wdata", m_data_wdata, 32'h1234_5678);
    step;
    drive(1'b1, MemLw, 32'h10, 32'h0, 32'h3020, 1'b1, 5'd9, 32'h0);
    step;
    check("lw_wdata", w_grf_wdata, 32'h1234_5678);
    check("lw_we", 32'(w_grf_we), 32'h1);
    check("lw_pc", w_inst_addr, 32'h3020);

    // Non-memory instruction passes wb data through
    drive(1'b1, MemNone, 32'h3, 32'h0, 32'h3024, 1'b1, 5'd10, 32'hCAFE_F00D);
    check("alu_byteen", 32'(m_data_byteen), 32'h0);
    step;
    check("alu_wdata", w_grf_wdata, 32'hCAFE_F00D);
    check("alu_err", 32'(err), 32'h0);

    // Misaligned LW then misaligned SH
    drive(1'b1, MemLw, 32'h3, 32'h0, 32'h3010, 1'b1, 5'd11, 32'h0);
    check("mis_lw_byteen", 32'(m_data_byteen), 32'h0);
    step;
    check("mis_lw_we", 32'(w_grf_we), 32'h0);
    check("mis_lw_err", 32'(err), 32'h1);
    check("mis_lw_cnt", 32'(err_cnt), 32'h1);
    drive(1'b1, MemSh, 32'h5, 32'h1111_2222, 32'h3014, 1'b0, 5'd0, 32'h0);
    check("mis_sh_byteen", 32'(m_data_byteen), 32'h0);
    step;
    check("mis_sh_we", 32'(w_grf_we), 32'h0);
    check("mis_err", 32'(err), 32'h1);
    check("mis_err_pc", err_pc, 32'h3010);
    check("mis_err_cnt", 32'(err_cnt), 32'h2);

    // Out-of-range store
    drive(1'b1, MemSw, 32'h4000, 32'h5555_5555, 32'h3018, 1'b0, 5'd0, 32'h0);
    check("oor_byteen", 32'(m_data_byteen), 32'h0);
    step;
    check("oor_cnt", 32'(err_cnt), 32'h3);
    check("oor_err_pc", err_pc, 32'h3010);

    // Bubble with misaligned address is not a fault
    drive(1'b0, MemLw, 32'h3, 32'h0, 32'h301C, 1'b1, 5'd1, 32'h0);
    step;
    check("bubble_cnt", 32'(err_cnt), 32'h3);
    check("bubble_we", 32'(w_grf_we), 32'h0);

    // Last in-range byte is not out of range
    drive(1'b1, MemLb, 32'h3FFF, 32'h0, 32'h3020, 1'b1, 5'd2, 32'h0);
    step;
    check("edge_cnt", 32'(err_cnt), 32'h3);
    check("edge_we", 32'(w_grf_we), 32'h1);

    // Saturation
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, MemSw, 32'h4000, 32'h0, 32'h4000 + 32'(i), 1'b0, 5'd0, 32'h0);
      step;
    end
    check("sat_cnt", 32'(err_cnt), 32'hFF);
    check("sat_err_pc", err_pc, 32'h3010);

    // Reset pulse with a valid store in M
    drive(1'b1, MemSw, 32'h100, 32'h0000_0055, 32'h3100, 1'b1, 5'd4, 32'h77);
    reset = 1'b1;
    #1;
    check("rst2_byteen", 32'(m_data_byteen), 32'h0);
    step;
    check("rst2_w_we", 32'(w_grf_we), 32'h0);
    check("rst2_w_addr", 32'(w_grf_addr), 32'h0);
    check("rst2_w_wdata", w_grf_wdata, 32'h0);
    check("rst2_w_pc", w_inst_addr, 32'h0);
    check("rst2_err", 32'(err), 32'h0);
    check("rst2_err_pc", err_pc, 32'h0);
    check("rst2_err_cnt", 32'(err_cnt), 32'h0);
    @(negedge clk);
    reset   = 1'b0;
    m_valid = 1'b0;
    drive(1'b1, MemLw, 32'h100, 32'h0, 32'h3104, 1'b1, 5'd3, 32'h0);
    step;
    check("rst2_no_write", w_grf_wdata, 32'h0);
    check("rst2_lw_we", 32'(w_grf_we), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dm_ctrl.md
# dm_ctrl

M/W-stage data-memory controller of the P6 pipelined MIPS core: the initiator side of the core's data-memory bus. Turns the M-stage load/store request into `m_data_addr`/`m_data_wdata`/`m_data_byteen`/`m_inst_addr`, and latches the returned word into the M/W register. Extracts and sign/zero-extends load data in W and drives the architectural write-back trace ports `w_grf_*`/`w_inst_addr`. Also detects misaligned or out-of-range accesses and keeps sticky error state.

## Interface
- `DM_WORDS`, 4096, data-memory size in 32-bit words; byte addresses ≥ DM_WORDS*4 are out of range.
- `clk`  in  1  core clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `m_valid`  in  1  M stage holds a real instruction (0 = bubble).
- `m_pc`  in  32  PC of M-stage instruction.
- `m_mem_op`  in  4  memory op code: NONE, LW, LH, LHU, LB, LBU, SW, SH, SB.
- `m_addr`  in  32  effective byte address (ALU result).
- `m_store_data`  in  32  forwarded rt value.
- `m_grf_we`  in  1  instruction writes GRF.
- `m_grf_addr`  in  5  destination register.
- `m_wb_data`  in  32  write-back value for non-load instructions.
- `m_data_addr`  out  32  data-memory byte address.
- `m_data_wdata`  out  32  lane-replicated store data.
- `m_data_byteen`  out  4  byte write enables (0 = no write).
- `m_inst_addr`  out  32  PC of the access, for trace.
- `m_data_rdata`  in  32  word at `m_data_addr`, valid combinationally in the same cycle.
- `w_grf_we`  out  1  registered GRF write enable.
- `w_grf_addr`  out  5  registered destination.
- `w_grf_wdata`  out  32  write-back data.
- `w_inst_addr`  out  32  registered PC of W instruction.
- `err`  out  1  sticky access-error flag.
- `err_pc`  out  32  PC of the first faulting access.
- `err_cnt`  out  8  saturating count of faulting accesses.

## Operation
- `m_data_addr = m_addr` unmodified.
- `m_inst_addr = m_pc`.
- Fault condition (`fault`): `m_valid` and a memory op with either of:
  - misalignment: word op with addr[1:0]≠0, or half op with addr[0]=1;
  - out of range: addr ≥ DM_WORDS*4.
- Byte enables: forced 0 when `fault`, `!m_valid`, `reset`, or a non-store op. Otherwise:
  - SW → 1111.
  - SH → 0011 if addr[1]=0, 1100 if addr[1]=1.
  - SB → 0001 << addr[1:0].
- Store data lanes:
  - SW: the word.
  - SH: {2{data[15:0]}}.
  - SB: {4{data[7:0]}}.
- M/W register captures: we, grf_addr, pc, op, addr[1:0], `m_wb_data`, and raw `m_data_rdata`.
- Captured we = `m_valid & m_grf_we & !fault`. A faulting load never writes the GRF.
- W extraction from the registered word:
  - LW: whole word.
  - LH / LHU: halfword at addr[1], sign-/zero-extended.
  - LB / LBU: byte at addr[1:0], sign-/zero-extended.
  - Non-load: registered `m_wb_data`.
- Error tracking:
  - On each fault edge, `err` is set.
  - `err_pc` loads `m_pc` only while `err`=0, so it holds the first fault.
  - `err_cnt` increments, saturating at 255.
  - Error state is cleared only by reset.

## Timing
- `m_data_*` outputs are combinational from M inputs, in the same cycle.
- The store commits at the next rising edge.
- `w_*` outputs change one cycle after M. A load's value appears on `w_grf_wdata` in the cycle after its M cycle.
- Reset values: all `w_*` = 0, `err`=0, `err_pc`=0, `err_cnt`=0. `m_data_byteen`=0 while reset is high.
- Reset asserted mid-stream: the in-flight M access is dropped (no byteen), and the W register is zeroed at that edge.
- Back-to-back store then load to the same word: the load reads the pre-store memory only if issued in the same cycle, which cannot happen. Consecutive cycles are correct by construction.
- No stall or flush inputs: the M/W register loads every cycle.

## Structure
- Shared package `mips_defs`: `m_mem_op` encodings (NONE=0, LW, LH, LHU, LB, LBU, SW, SH, SB), plus helpers `is_load` / `is_store`.
- Sub-module `dm_ext`: combinational load extractor. Inputs are op, addr[1:0], and word; output is the 32-bit result. Instantiated in W.

## Test plan
- SB 0xAB at 0x00000006, word previously 0 → byteen=0100, wdata=0xABABABAB. Next-cycle LB from 0x6 → `w_grf_wdata`=0xFFFFFFAB; LBU → 0x000000AB.
- SH 0x8001 at 0x2, then LH 0x2 → byteen=1100, `w_grf_wdata`=0xFFFF8001; LHU → 0x00008001.
- SW 0x12345678 at 0x10, then LW 0x10 → byteen=1111, `w_grf_wdata`=0x12345678, `w_grf_we`=1, `w_inst_addr`=load PC.
- LW at 0x3 (PC 0x3010), then SH at 0x5 (PC 0x3014):
  - both: byteen=0, `w_grf_we`=0;
  - `err`=1, `err_pc`=0x3010, `err_cnt`=2.
- SW to 0x4000 with DM_WORDS=4096 → out of range, byteen=0, `err_cnt` increments. 300 faults → `err_cnt`=255.
- Reset pulsed for one cycle with a valid SW in M → no write issued, all `w_*`=0 next cycle, error state cleared.
